// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the RV32I load/store funct3 encodings, the LSU state and fault-code
// enums, and small decode helpers used by the top level.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ERR
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } lsu_fault_e;

  // Stores only have signed-width encodings; loads also allow the unsigned ones.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req   request, held until mem_ack
//   mem_we    1 = write
//   mem_addr  word-aligned byte address
//   mem_wdata lane-replicated store data
//   mem_be    byte enables
//   mem_ack   completion; mem_rdata valid with it
//   mem_rdata read word
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Combinational load-data formatter.
//   word    raw 32-bit bus read word
//   offset  byte offset of the access within the word
//   funct3  load type (LB/LH/LW/LBU/LHU)
//   result  extracted and sign/zero-extended value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Move the addressed byte/halfword down to bit 0.
  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted; // word accesses are aligned, so no shift
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine of the RV32I core.
// Accepts one load or store from EX, runs a req/ack transaction on the data bus
// and reports completion with done (qualified by fault/fault_code).
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle request, sampled in IDLE only
//   is_load, is_store    direction
//   funct3, addr, wdata  access type, byte address, store data
//   busy                 high outside IDLE (pipeline stall)
//   done                 one-cycle completion pulse
//   rdata_out            formatted load result, held until next successful load
//   fault, fault_code    error qualifier for done
//   bus                  data-memory bus (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        fault,
  output logic [1:0]  fault_code,
  lsu_if.master       bus
);

  lsu_state_e           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fault_q;
  lsu_fault_e           fault_code_q;
  logic [31:0]          rdata_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [31:0]          mem_addr_q;
  logic [31:0]          mem_wdata_q;
  logic [3:0]           mem_be_q;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;
  logic [TIMEOUT_W-1:0] count_q;

  lsu_fault_e  req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_word;

  // Request decode; illegal encodings take priority over misalignment.
  always_comb begin
    req_err = FLT_NONE;
    if (is_load && is_store) begin
      req_err = FLT_ILLEGAL;
    end else if (!f3_legal(is_store, funct3)) begin
      req_err = FLT_ILLEGAL;
    end else if (f3_misaligned(funct3, addr[1:0])) begin
      req_err = FLT_MISALIGN;
    end
  end

  // Lane steering; loads drive the same enables for information only.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << addr[1:0];
        req_wdata = {2{wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

  load_extend u_load_extend (
    .word   (bus.mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      count_q      <= '0;
    end else begin
      // done/fault are single-cycle pulses, re-asserted only on entry to RESP/ERR.
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      case (state_q)
        IDLE: begin
          if (start && (is_load || is_store)) begin
            busy_q <= 1'b1;
            if (req_err != FLT_NONE) begin
              state_q      <= ERR;
              done_q       <= 1'b1;
              fault_q      <= 1'b1;
              fault_code_q <= req_err;
            end else begin
              state_q     <= WAIT;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= req_wdata;
              mem_be_q    <= req_be;
              funct3_q    <= funct3;
              offset_q    <= addr[1:0];
              count_q     <= '0;
            end
          end
        end
        WAIT: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (bus.mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (!mem_we_q) begin
              rdata_q <= load_word;
            end
          end else if ((TIMEOUT_CYCLES != 0) &&
                       (count_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1))) begin
            state_q      <= ERR;
            mem_req_q    <= 1'b0;
            done_q       <= 1'b1;
            fault_q      <= 1'b1;
            fault_code_q <= FLT_TIMEOUT;
          end else begin
            count_q <= count_q + TIMEOUT_W'(1);
          end
        end
        RESP, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign rdata_out     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata_out;
  logic        fault;
  logic [1:0]  fault_code;

  lsu_if bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata_out  (rdata_out),
    .fault      (fault),
    .fault_code (fault_code),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results of the last access() call.
  int          done_cyc;
  int          req_cycles;
  logic        busy_ok;
  logic        got_fault;
  logic [1:0]  got_code;
  logic        c1_req;
  logic        c1_we;
  logic [31:0] c1_addr;
  logic [31:0] c1_wdata;
  logic [3:0]  c1_be;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and observe up to 12 cycles; ack_at=0 never acks.
  // Cycle numbering: start is in cycle 0; all observation is on negedges.
  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd);
    int cyc;
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cyc        = 1;
    done_cyc   = -1;
    req_cycles = 0;
    busy_ok    = 1'b1;
    got_fault  = 1'b0;
    got_code   = 2'b00;
    while (cyc <= 12 && done_cyc < 0) begin
      bus.mem_ack   = (cyc == ack_at);
      bus.mem_rdata = rd;
      if (cyc == 1) begin
        c1_req   = bus.mem_req;
        c1_we    = bus.mem_we;
        c1_addr  = bus.mem_addr;
        c1_wdata = bus.mem_wdata;
        c1_be    = bus.mem_be;
      end
      if (bus.mem_req) req_cycles++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cyc  = cyc;
        got_fault = fault;
        got_code  = fault_code;
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    logic saw_done;
    rst_n         = 1'b0;
    start         = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    funct3        = 3'b000;
    addr          = '0;
    wdata         = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fault", {31'd0, fault} | {30'd0, fault_code}, 32'd0);
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'd0);
    check_eq("rst_be", 32'(bus.mem_be), 32'd0);
    check_eq("rst_rdata", rdata_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LW 0x100, ack in cycle 1
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    check_eq("lw_req", 32'(c1_req), 32'd1);
    check_eq("lw_addr", c1_addr, 32'h100);
    check_eq("lw_we", 32'(c1_we), 32'd0);
    check_eq("lw_done_cyc", 32'(done_cyc), 32'd2);
    check_eq("lw_fault", 32'(got_fault), 32'd0);
    check_eq("lw_rdata", rdata_out, 32'hDEADBEEF);
    check_eq("lw_idle_busy", 32'(busy), 32'd0);

    // LB / LBU at offset 3, three wait cycles then ack
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 4, 32'h80FF0000);
    check_eq("lb_be", 32'(c1_be), 32'h8);
    check_eq("lb_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("lb_busy_held", 32'(busy_ok), 32'd1);
    check_eq("lb_rdata", rdata_out, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 4, 32'h80FF0000);
    check_eq("lbu_fault", 32'(got_fault), 32'd0);
    check_eq("lbu_rdata", rdata_out, 32'h00000080);

    // LH / LHU upper half
    access(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 2, 32'h80011234);
    check_eq("lh_rdata", rdata_out, 32'hFFFF8001);
    access(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 1, 32'h80011234);
    check_eq("lhu_rdata", rdata_out, 32'h00008001);

    // SH 0x22
    access(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 2, 32'h55555555);
    check_eq("sh_addr", c1_addr, 32'h20);
    check_eq("sh_be", 32'(c1_be), 32'hC);
    check_eq("sh_wdata", c1_wdata, 32'hABCDABCD);
    check_eq("sh_we", 32'(c1_we), 32'd1);
    check_eq("sh_done_cyc", 32'(done_cyc), 32'd3);
    check_eq("sh_rdata_kept", rdata_out, 32'h00008001);

    // SB 0x101
    access(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 1, 32'h0);
    check_eq("sb_be", 32'(c1_be), 32'h2);
    check_eq("sb_wdata", c1_wdata, 32'hA5A5A5A5);

    // Error paths
    access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
    check_eq("mis_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("mis_fault", 32'(got_fault), 32'd1);
    check_eq("mis_code", 32'(got_code), 32'd1);
    check_eq("mis_no_req", 32'(req_cycles), 32'd0);
    access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
    check_eq("both_code", 32'(got_code), 32'd3);
    check_eq("both_no_req", 32'(req_cycles), 32'd0);
    access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
    check_eq("st_f3_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("st_f3_code", 32'(got_code), 32'd3);
    access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h0);
    check_eq("neither_ignored", 32'(done_cyc), 32'hFFFFFFFF);
    check_eq("neither_no_req", 32'(req_cycles), 32'd0);

    // Timeout with no ack, then ack in the expiry cycle
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h0);
    check_eq("to_req_cycles", 32'(req_cycles), 32'd4);
    check_eq("to_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("to_fault", 32'(got_fault), 32'd1);
    check_eq("to_code", 32'(got_code), 32'd2);
    check_eq("to_rdata_kept", rdata_out, 32'h00008001);
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 4, 32'h13579BDF);
    check_eq("to_ack_fault", 32'(got_fault), 32'd0);
    check_eq("to_ack_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("to_ack_rdata", rdata_out, 32'h13579BDF);

    // Reset in the second WAIT cycle
    is_load  = 1'b1;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h300;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("rw_req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rw_req", 32'(bus.mem_req), 32'd0);
    check_eq("rw_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    check_eq("rw_no_done", 32'(saw_done), 32'd0);
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'hCAFEF00D);
    check_eq("rw_after_done_cyc", 32'(done_cyc), 32'd2);
    check_eq("rw_after_rdata", rdata_out, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
